// File: rtl/i2c_master_byte_ctrl_if.sv
// Bundle of signals between the I2C byte controller, the host/register layer
// above it and the bit controller below it. Suffixes are from the byte
// controller's point of view.
interface i2c_master_byte_ctrl_if;
  // Host side
  logic       enable_i;
  logic       start_i;
  logic       stop_i;
  logic       read_i;
  logic       write_i;
  logic       ack_in_i;
  logic [7:0] din_i;
  logic       cmd_ack_o;
  logic       ack_out_o;
  logic [7:0] dout_o;
  logic       busy_o;
  // Bit-controller side
  logic [3:0] bit_cmd_o;
  logic       bit_ack_i;
  logic       bit_txd_o;
  logic       bit_rxd_i;
  logic       i2c_al_i;

  // The byte controller itself
  modport master (
    input  enable_i, start_i, stop_i, read_i, write_i, ack_in_i, din_i,
    output cmd_ack_o, ack_out_o, dout_o, busy_o,
    output bit_cmd_o, bit_txd_o,
    input  bit_ack_i, bit_rxd_i, i2c_al_i
  );

  // Whatever surrounds it (host plus bit controller)
  modport slave (
    output enable_i, start_i, stop_i, read_i, write_i, ack_in_i, din_i,
    input  cmd_ack_o, ack_out_o, dout_o, busy_o,
    input  bit_cmd_o, bit_txd_o,
    output bit_ack_i, bit_rxd_i, i2c_al_i
  );
endinterface

// File: rtl/i2c_master_byte_ctrl.sv
// I2C byte controller: turns one host byte transaction (optional START,
// one WRITE or READ byte, ACK bit, optional STOP) into a sequence of single
// bit commands on the bit controller's cmd/ack handshake. Data goes out
// MSB-first; received bits are shifted into the same register.
module i2c_master_byte_ctrl (
  input  logic                    clk_i,
  input  logic                    rst_i,
  i2c_master_byte_ctrl_if.master  bus
);

  // Bit-controller command encodings (shared with the bit controller)
  localparam logic [3:0] I2C_CMD_NOP   = 4'b0000;
  localparam logic [3:0] I2C_CMD_START = 4'b0001;
  localparam logic [3:0] I2C_CMD_STOP  = 4'b0010;
  localparam logic [3:0] I2C_CMD_WRITE = 4'b0100;
  localparam logic [3:0] I2C_CMD_READ  = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WRITE,
    ST_READ,
    ST_ACK,
    ST_STOP
  } state_t;

  state_t     state_q,   state_d;
  logic [3:0] bit_cmd_q, bit_cmd_d;
  logic       cmd_ack_q, cmd_ack_d;
  logic       ack_out_q, ack_out_d;
  logic [7:0] sr_q,      sr_d;
  logic [2:0] cnt_q,     cnt_d;

  logic       go;
  logic       abort;

  // A request is a level held until cmd_ack; masking with cmd_ack_q keeps
  // the still-high request from re-launching in the acknowledge cycle.
  assign go    = (bus.read_i | bus.write_i | bus.stop_i) & ~cmd_ack_q;
  // Arbitration loss and core disable share the same synchronous abort.
  assign abort = bus.i2c_al_i | ~bus.enable_i;

  // State register and all registered outputs
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      bit_cmd_q <= I2C_CMD_NOP;
      cmd_ack_q <= 1'b0;
      ack_out_q <= 1'b0;
      sr_q      <= 8'h00;
      cnt_q     <= 3'd0;
    end else begin
      state_q   <= state_d;
      bit_cmd_q <= bit_cmd_d;
      cmd_ack_q <= cmd_ack_d;
      ack_out_q <= ack_out_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state, bit command and datapath updates
  always_comb begin
    // NOTE: every _d gets a hold default before any branch, so no path can
    // leave a signal unassigned and infer a latch.
    state_d   = state_q;
    bit_cmd_d = bit_cmd_q;
    cmd_ack_d = 1'b0;
    ack_out_d = ack_out_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;

    if (abort) begin
      // Drop the transaction silently; captured data is left untouched.
      state_d   = ST_IDLE;
      bit_cmd_d = I2C_CMD_NOP;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (go) begin
            sr_d  = bus.din_i;
            cnt_d = 3'd7;
            if (bus.start_i) begin
              state_d   = ST_START;
              bit_cmd_d = I2C_CMD_START;
            end else if (bus.read_i) begin
              state_d   = ST_READ;
              bit_cmd_d = I2C_CMD_READ;
            end else if (bus.write_i) begin
              state_d   = ST_WRITE;
              bit_cmd_d = I2C_CMD_WRITE;
            end else begin
              state_d   = ST_STOP;
              bit_cmd_d = I2C_CMD_STOP;
            end
          end
        end

        ST_START: begin
          if (bus.bit_ack_i) begin
            if (bus.read_i) begin
              state_d   = ST_READ;
              bit_cmd_d = I2C_CMD_READ;
            end else begin
              state_d   = ST_WRITE;
              bit_cmd_d = I2C_CMD_WRITE;
            end
          end
        end

        ST_WRITE, ST_READ: begin
          if (bus.bit_ack_i) begin
            // Same shift for both directions: on a write the returned bit
            // is just the line echo, on a read it is the data.
            sr_d = {sr_q[6:0], bus.bit_rxd_i};
            if (cnt_q == 3'd0) begin
              state_d   = ST_ACK;
              // Write: listen for the slave's ACK. Read: drive ack_in.
              bit_cmd_d = (state_q == ST_WRITE) ? I2C_CMD_READ : I2C_CMD_WRITE;
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end
        end

        ST_ACK: begin
          if (bus.bit_ack_i) begin
            ack_out_d = bus.bit_rxd_i;
            if (bus.stop_i) begin
              state_d   = ST_STOP;
              bit_cmd_d = I2C_CMD_STOP;
            end else begin
              state_d   = ST_IDLE;
              bit_cmd_d = I2C_CMD_NOP;
              cmd_ack_d = 1'b1;
            end
          end
        end

        ST_STOP: begin
          if (bus.bit_ack_i) begin
            state_d   = ST_IDLE;
            bit_cmd_d = I2C_CMD_NOP;
            cmd_ack_d = 1'b1;
          end
        end

        default: begin
          state_d   = ST_IDLE;
          bit_cmd_d = I2C_CMD_NOP;
        end
      endcase
    end
  end

  // Outputs: the data bit follows registered state only, so it is stable for
  // the full length of a (possibly stretched) bit command.
  assign bus.bit_txd_o = (state_q == ST_ACK) ? bus.ack_in_i : sr_q[7];
  assign bus.bit_cmd_o = bit_cmd_q;
  assign bus.cmd_ack_o = cmd_ack_q;
  assign bus.ack_out_o = ack_out_q;
  assign bus.dout_o    = sr_q;
  assign bus.busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Directed bench for the I2C byte controller. A behavioural bit-controller
// model answers each bit command after a programmable delay, logs every
// command with its data bit, and flags any change of cmd/txd mid-command.
module tb_i2c_master_byte_ctrl;

  localparam logic [3:0] CMD_NOP   = 4'b0000;
  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_STOP  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b1000;

  logic clk = 1'b0;
  logic rst;

  i2c_master_byte_ctrl_if bus ();

  i2c_master_byte_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bit-controller model state
  int         model_delay = 3;
  bit         rx_q[$];
  logic [3:0] log_cmd[$];
  logic       log_txd[$];
  int         stab_err = 0;
  int         ack_pulses = 0;

  always @(negedge clk) if (bus.cmd_ack_o === 1'b1) ack_pulses++;

  // Bit-controller model: one command at a time, acked model_delay cycles
  // after it appears; a return to NOP means the byte controller aborted.
  initial begin
    int         wait_left;
    bit         active;
    logic [3:0] cur_cmd;
    logic       cur_txd;
    active = 1'b0;
    wait_left = 0;
    cur_cmd = CMD_NOP;
    cur_txd = 1'b0;
    bus.bit_ack_i = 1'b0;
    bus.bit_rxd_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.bit_ack_i = 1'b0;
      if (active) begin
        if (bus.bit_cmd_o === CMD_NOP) begin
          active = 1'b0;
        end else begin
          if (bus.bit_cmd_o !== cur_cmd || bus.bit_txd_o !== cur_txd) stab_err++;
          if (wait_left == 0) begin
            bus.bit_ack_i = 1'b1;
            if (cur_cmd == CMD_READ) begin
              if (rx_q.size() > 0) bus.bit_rxd_i = rx_q.pop_front();
              else bus.bit_rxd_i = 1'b0;
            end else begin
              bus.bit_rxd_i = cur_txd;
            end
            active = 1'b0;
          end else begin
            wait_left--;
          end
        end
      end else if (bus.bit_cmd_o !== CMD_NOP && rst === 1'b0) begin
        cur_cmd   = bus.bit_cmd_o;
        cur_txd   = bus.bit_txd_o;
        log_cmd.push_back(cur_cmd);
        log_txd.push_back(cur_txd);
        wait_left = model_delay - 1;
        active    = 1'b1;
      end
    end
  end

  // Host driver: hold the request until cmd_ack, keep it one more cycle to
  // prove it is not reissued, then release.
  task automatic run_txn(input bit s, input bit p, input bit r, input bit w,
                         input bit a, input logic [7:0] d, input int budget,
                         output int cycles, output bit done);
    bus.start_i  = s;
    bus.stop_i   = p;
    bus.read_i   = r;
    bus.write_i  = w;
    bus.ack_in_i = a;
    bus.din_i    = d;
    cycles = 0;
    done   = 1'b0;
    while (cycles < budget && !done) begin
      @(posedge clk);
      #1;
      cycles++;
      if (bus.cmd_ack_o === 1'b1) done = 1'b1;
    end
    if (done) begin
      @(posedge clk);
      #1;
    end
    bus.start_i = 1'b0;
    bus.stop_i  = 1'b0;
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.bit_cmd_o !== CMD_NOP) begin errors++; $display("FAIL reset_bit_cmd: got %h expected %h", bus.bit_cmd_o, CMD_NOP); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
    checks++; if (bus.cmd_ack_o !== 1'b0) begin errors++; $display("FAIL reset_cmd_ack: got %b expected 0", bus.cmd_ack_o); end
    checks++; if (bus.ack_out_o !== 1'b0) begin errors++; $display("FAIL reset_ack_out: got %b expected 0", bus.ack_out_o); end
    checks++; if (bus.dout_o !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", bus.dout_o); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_start_write();
    int base, p0, cyc;
    bit done;
    logic [7:0] exp_bits;
    exp_bits = 8'b1010_0101;
    model_delay = 3;
    rx_q.delete();
    rx_q.push_back(1'b0);
    base = log_cmd.size();
    p0   = ack_pulses;
    run_txn(1, 0, 0, 1, 0, 8'hA5, 2000, cyc, done);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL sw_done: got %b expected 1", done); end
    checks++; if (log_cmd.size() - base !== 10) begin errors++; $display("FAIL sw_cmd_count: got %0d expected 10", log_cmd.size() - base); end
    else begin
      checks++; if (log_cmd[base] !== CMD_START) begin errors++; $display("FAIL sw_start: got %h expected %h", log_cmd[base], CMD_START); end
      for (int i = 0; i < 8; i++) begin
        checks++; if (log_cmd[base+1+i] !== CMD_WRITE || log_txd[base+1+i] !== exp_bits[7-i]) begin
          errors++; $display("FAIL sw_bit%0d: got cmd %h txd %b expected cmd %h txd %b", i, log_cmd[base+1+i], log_txd[base+1+i], CMD_WRITE, exp_bits[7-i]);
        end
      end
      checks++; if (log_cmd[base+9] !== CMD_READ) begin errors++; $display("FAIL sw_ack_cmd: got %h expected %h", log_cmd[base+9], CMD_READ); end
    end
    checks++; if (bus.ack_out_o !== 1'b0) begin errors++; $display("FAIL sw_ack_out: got %b expected 0", bus.ack_out_o); end
    checks++; if (ack_pulses - p0 !== 1) begin errors++; $display("FAIL sw_cmd_ack_pulses: got %0d expected 1", ack_pulses - p0); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL sw_busy_after: got %b expected 0", bus.busy_o); end
  endtask

  task automatic test_read_stop();
    int base, p0, cyc;
    bit done;
    model_delay = 3;
    rx_q.delete();
    rx_q = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    base = log_cmd.size();
    p0   = ack_pulses;
    bus.start_i  = 1'b0;
    bus.stop_i   = 1'b1;
    bus.read_i   = 1'b1;
    bus.ack_in_i = 1'b1;
    bus.din_i    = 8'h00;
    done = 1'b0;
    cyc  = 0;
    while (cyc < 2000 && !done) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.cmd_ack_o === 1'b1) done = 1'b1;
    end
    // Dout is only guaranteed in the cmd_ack cycle itself
    checks++; if (bus.dout_o !== 8'h3C) begin errors++; $display("FAIL rs_dout: got %h expected 3c", bus.dout_o); end
    @(posedge clk);
    #1;
    bus.stop_i = 1'b0;
    bus.read_i = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rs_done: got %b expected 1", done); end
    checks++; if (log_cmd.size() - base !== 10) begin errors++; $display("FAIL rs_cmd_count: got %0d expected 10", log_cmd.size() - base); end
    else begin
      for (int i = 0; i < 8; i++) begin
        checks++; if (log_cmd[base+i] !== CMD_READ) begin errors++; $display("FAIL rs_read%0d: got %h expected %h", i, log_cmd[base+i], CMD_READ); end
      end
      checks++; if (log_cmd[base+8] !== CMD_WRITE || log_txd[base+8] !== 1'b1) begin
        errors++; $display("FAIL rs_ack_bit: got cmd %h txd %b expected cmd %h txd 1", log_cmd[base+8], log_txd[base+8], CMD_WRITE);
      end
      checks++; if (log_cmd[base+9] !== CMD_STOP) begin errors++; $display("FAIL rs_stop: got %h expected %h", log_cmd[base+9], CMD_STOP); end
    end
    checks++; if (bus.ack_out_o !== 1'b1) begin errors++; $display("FAIL rs_ack_out: got %b expected 1", bus.ack_out_o); end
    checks++; if (ack_pulses - p0 !== 1) begin errors++; $display("FAIL rs_cmd_ack_pulses: got %0d expected 1", ack_pulses - p0); end
  endtask

  task automatic test_stop_only();
    int base, p0, cyc;
    bit done;
    base = log_cmd.size();
    p0   = ack_pulses;
    run_txn(0, 1, 0, 0, 0, 8'h00, 200, cyc, done);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL so_done: got %b expected 1", done); end
    checks++; if (log_cmd.size() - base !== 1) begin errors++; $display("FAIL so_cmd_count: got %0d expected 1", log_cmd.size() - base); end
    else begin
      checks++; if (log_cmd[base] !== CMD_STOP) begin errors++; $display("FAIL so_cmd: got %h expected %h", log_cmd[base], CMD_STOP); end
    end
    checks++; if (ack_pulses - p0 !== 1) begin errors++; $display("FAIL so_cmd_ack_pulses: got %0d expected 1", ack_pulses - p0); end
    checks++; if (bus.ack_out_o !== 1'b1) begin errors++; $display("FAIL so_ack_out_kept: got %b expected 1", bus.ack_out_o); end
  endtask

  task automatic test_clock_stretch();
    int base, p0, s0, cyc;
    bit done;
    logic [7:0] exp_bits;
    exp_bits = 8'b0011_1100;
    model_delay = 50;
    rx_q.delete();
    rx_q.push_back(1'b0);
    base = log_cmd.size();
    p0   = ack_pulses;
    s0   = stab_err;
    run_txn(0, 0, 0, 1, 0, 8'h3C, 2000, cyc, done);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL cs_done: got %b expected 1", done); end
    // 1 launch cycle + 9 bit commands of (50 wait + 1 ack) cycles each
    checks++; if (cyc !== 460) begin errors++; $display("FAIL cs_length: got %0d expected 460", cyc); end
    checks++; if (stab_err - s0 !== 0) begin errors++; $display("FAIL cs_stability: got %0d changes expected 0", stab_err - s0); end
    checks++; if (ack_pulses - p0 !== 1) begin errors++; $display("FAIL cs_cmd_ack_pulses: got %0d expected 1", ack_pulses - p0); end
    checks++; if (log_cmd.size() - base !== 9) begin errors++; $display("FAIL cs_cmd_count: got %0d expected 9", log_cmd.size() - base); end
    else begin
      for (int i = 0; i < 8; i++) begin
        checks++; if (log_cmd[base+i] !== CMD_WRITE || log_txd[base+i] !== exp_bits[7-i]) begin
          errors++; $display("FAIL cs_bit%0d: got cmd %h txd %b expected cmd %h txd %b", i, log_cmd[base+i], log_txd[base+i], CMD_WRITE, exp_bits[7-i]);
        end
      end
    end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL cs_busy_after: got %b expected 0", bus.busy_o); end
    model_delay = 3;
  endtask

  task automatic test_arb_lost();
    int base, p0, cyc;
    bit done;
    logic [7:0] exp_bits;
    model_delay = 3;
    base = log_cmd.size();
    p0   = ack_pulses;
    bus.write_i = 1'b1;
    bus.din_i   = 8'h96;
    cyc = 0;
    while (cyc < 200 && log_cmd.size() < base + 4) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++; if (log_cmd.size() < base + 4) begin errors++; $display("FAIL al_reach_bit4: got %0d cmds expected 4", log_cmd.size() - base); end
    bus.i2c_al_i = 1'b1;
    bus.write_i  = 1'b0;
    @(posedge clk);
    #1;
    bus.i2c_al_i = 1'b0;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL al_busy: got %b expected 0", bus.busy_o); end
    checks++; if (bus.bit_cmd_o !== CMD_NOP) begin errors++; $display("FAIL al_bit_cmd: got %h expected %h", bus.bit_cmd_o, CMD_NOP); end
    checks++; if (bus.cmd_ack_o !== 1'b0) begin errors++; $display("FAIL al_cmd_ack: got %b expected 0", bus.cmd_ack_o); end
    // Three bits went out and echoed back: 0x96 rotated left by 3
    checks++; if (bus.dout_o !== 8'hB4) begin errors++; $display("FAIL al_dout_kept: got %h expected b4", bus.dout_o); end
    repeat (10) @(posedge clk);
    #1;
    checks++; if (ack_pulses - p0 !== 0) begin errors++; $display("FAIL al_no_cmd_ack: got %0d expected 0", ack_pulses - p0); end
    checks++; if (log_cmd.size() - base !== 4) begin errors++; $display("FAIL al_no_new_cmd: got %0d expected 4", log_cmd.size() - base); end

    // Fresh Write+Stop afterwards must run to completion
    exp_bits = 8'b0101_1010;
    rx_q.delete();
    base = log_cmd.size();
    p0   = ack_pulses;
    run_txn(0, 1, 0, 1, 0, 8'h5A, 2000, cyc, done);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL al_retry_done: got %b expected 1", done); end
    checks++; if (ack_pulses - p0 !== 1) begin errors++; $display("FAIL al_retry_pulses: got %0d expected 1", ack_pulses - p0); end
    checks++; if (log_cmd.size() - base !== 10) begin errors++; $display("FAIL al_retry_count: got %0d expected 10", log_cmd.size() - base); end
    else begin
      for (int i = 0; i < 8; i++) begin
        checks++; if (log_txd[base+i] !== exp_bits[7-i]) begin errors++; $display("FAIL al_retry_bit%0d: got %b expected %b", i, log_txd[base+i], exp_bits[7-i]); end
      end
      checks++; if (log_cmd[base+8] !== CMD_READ || log_cmd[base+9] !== CMD_STOP) begin
        errors++; $display("FAIL al_retry_tail: got %h %h expected %h %h", log_cmd[base+8], log_cmd[base+9], CMD_READ, CMD_STOP);
      end
    end
  endtask

  task automatic test_rst_enable_abort();
    int base, p0, cyc;
    bit done, stayed_idle;
    model_delay = 3;
    // Make ack_out and dout non-zero so the reset is visible
    rx_q.delete();
    run_txn(0, 0, 1, 0, 1, 8'h00, 2000, cyc, done);
    checks++; if (bus.ack_out_o !== 1'b1) begin errors++; $display("FAIL ra_setup_ack_out: got %b expected 1", bus.ack_out_o); end
    rx_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    base = log_cmd.size();
    p0   = ack_pulses;
    bus.read_i = 1'b1;
    cyc = 0;
    while (cyc < 200 && log_cmd.size() < base + 3) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    #2;
    rst = 1'b1;
    bus.read_i = 1'b0;
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL ra_rst_busy: got %b expected 0", bus.busy_o); end
    checks++; if (bus.bit_cmd_o !== CMD_NOP) begin errors++; $display("FAIL ra_rst_bit_cmd: got %h expected %h", bus.bit_cmd_o, CMD_NOP); end
    checks++; if (bus.dout_o !== 8'h00) begin errors++; $display("FAIL ra_rst_dout: got %h expected 00", bus.dout_o); end
    checks++; if (bus.ack_out_o !== 1'b0) begin errors++; $display("FAIL ra_rst_ack_out: got %b expected 0", bus.ack_out_o); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx_q.delete();
    repeat (5) @(posedge clk);
    #1;
    checks++; if (ack_pulses - p0 !== 0) begin errors++; $display("FAIL ra_rst_no_cmd_ack: got %0d expected 0", ack_pulses - p0); end

    // Enable dropped mid-write; request held while disabled must not start
    base = log_cmd.size();
    bus.write_i = 1'b1;
    bus.din_i   = 8'hC3;
    cyc = 0;
    while (cyc < 200 && log_cmd.size() < base + 2) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.enable_i = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL ra_en_busy: got %b expected 0", bus.busy_o); end
    checks++; if (bus.bit_cmd_o !== CMD_NOP) begin errors++; $display("FAIL ra_en_bit_cmd: got %h expected %h", bus.bit_cmd_o, CMD_NOP); end
    checks++; if (bus.cmd_ack_o !== 1'b0) begin errors++; $display("FAIL ra_en_cmd_ack: got %b expected 0", bus.cmd_ack_o); end
    base = log_cmd.size();
    stayed_idle = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.busy_o !== 1'b0 || bus.bit_cmd_o !== CMD_NOP) stayed_idle = 1'b0;
    end
    checks++; if (stayed_idle !== 1'b1) begin errors++; $display("FAIL ra_en_stays_idle: got %b expected 1", stayed_idle); end
    checks++; if (log_cmd.size() - base !== 0) begin errors++; $display("FAIL ra_en_no_cmds: got %0d expected 0", log_cmd.size() - base); end
    bus.write_i  = 1'b0;
    bus.enable_i = 1'b1;
    @(posedge clk);
    #1;

    // Clean write of 0xFF afterwards
    base = log_cmd.size();
    run_txn(0, 0, 0, 1, 0, 8'hFF, 2000, cyc, done);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ra_ff_done: got %b expected 1", done); end
    checks++; if (log_cmd.size() - base !== 9) begin errors++; $display("FAIL ra_ff_count: got %0d expected 9", log_cmd.size() - base); end
    else begin
      for (int i = 0; i < 8; i++) begin
        checks++; if (log_cmd[base+i] !== CMD_WRITE || log_txd[base+i] !== 1'b1) begin
          errors++; $display("FAIL ra_ff_bit%0d: got cmd %h txd %b expected cmd %h txd 1", i, log_cmd[base+i], log_txd[base+i], CMD_WRITE);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.enable_i = 1'b1;
    bus.start_i  = 1'b0;
    bus.stop_i   = 1'b0;
    bus.read_i   = 1'b0;
    bus.write_i  = 1'b0;
    bus.ack_in_i = 1'b0;
    bus.din_i    = 8'h00;
    bus.i2c_al_i = 1'b0;

    test_reset();
    test_start_write();
    test_read_stop();
    test_stop_only();
    test_clock_stretch();
    test_arb_lost();
    test_rst_enable_abort();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
